// File: rtl/fb_line_fetch_arbiter.sv
// Framebuffer port arbiter with a line-prefetch sequencer.
// A line request bursts one LINE_W-pixel row into a ping-pong line buffer.
// Writer words are granted only in idle memory cycles, so fetches never stall.
module fb_line_fetch_arbiter #(
  parameter int LINE_W = 480,
  parameter int LINES  = 272,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [8:0]        line_idx,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [9:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              busy,
  output logic              req_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t            state, state_nxt;
  logic              bank;
  logic [8:0]        x;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] line_base;
  logic              idx_ok, accept, grant, drop, fetch_last;

  // Row start address; LINE_W*LINES fits ADDR_W, so no overflow.
  assign line_base = ADDR_W'(line_idx) * ADDR_W'(LINE_W);
  assign idx_ok    = 32'(line_idx) < LINES;
  assign busy      = (state == FETCH) || (state == DRAIN);
  // Read data arrives one cycle after the address, aligned with lb_we/lb_addr.
  assign lb_wdata  = mem_rdata;

  // Next-state and arbitration decisions; line requests beat the writer.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    grant      = 1'b0;
    fetch_last = (x == 9'(LINE_W - 1));
    case (state)
      IDLE: begin
        if (line_req && idx_ok) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end else if (wr_req) begin
          grant     = 1'b1;
          state_nxt = WRITE;
        end
      end
      FETCH:   if (fetch_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      // The writer still holds wr_req while it samples the ack.
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    drop = line_req && !accept;
  end

  // State, fetch counters and registered memory / line-buffer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bank      <= 1'b0;
      x         <= '0;
      base      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      req_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_we  <= grant;
      wr_ack  <= grant;
      req_err <= drop;
      // Line-buffer write trails each read by one cycle.
      lb_we   <= (state == FETCH);
      if (state == FETCH) lb_addr <= {bank, x};
      if (accept) begin
        base     <= line_base;
        bank     <= ~bank;
        x        <= '0;
        mem_addr <= line_base;
      end else if (grant) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (state == FETCH && !fetch_last) begin
        x        <= x + 9'd1;
        mem_addr <= base + ADDR_W'(x) + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fb_line_fetch_arbiter.sv
// Directed bench for fb_line_fetch_arbiter with a behavioural framebuffer.
module tb_fb_line_fetch_arbiter;
  localparam int LW = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_req = 1'b0;
  logic [8:0]  line_idx = '0;
  logic        wr_req = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_wdata;
  logic        busy;
  logic        req_err;

  int n_chk = 0;
  int n_fail = 0;

  bit [7:0] wmem [0:131071];
  bit       wvld [0:131071];

  fb_line_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_idx(line_idx),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 13 + (a >> 7));
  endfunction

  // Framebuffer: preset pattern until overwritten, one-cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= wvld[mem_addr] ? wmem[mem_addr] : pat(int'(mem_addr));
    if (mem_we) begin
      wmem[mem_addr] <= mem_wdata;
      wvld[mem_addr] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a line request and check every cycle of the fetch window.
  task automatic run_fetch(input string name, input logic [8:0] idx,
                           input logic exp_bank, input int err_at);
    int b;
    logic exp_lb, exp_err;
    b = int'(idx) * LW;
    line_req = 1'b1;
    line_idx = idx;
    tick();
    line_req = 1'b0;
    for (int c = 1; c <= LW + 2; c++) begin
      n_chk++;
      if (busy !== (c <= LW + 1)) begin
        n_fail++;
        $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, (c <= LW + 1));
      end
      if (c <= LW) begin
        n_chk++;
        if (mem_addr !== 17'(b + c - 1)) begin
          n_fail++;
          $display("FAIL %s mem_addr c=%0d got %0d exp %0d", name, c, mem_addr, b + c - 1);
        end
      end
      n_chk++;
      if (mem_we !== 1'b0 || wr_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL %s write during fetch c=%0d got we=%b ack=%b exp 0", name, c, mem_we, wr_ack);
      end
      exp_lb = (c >= 2) && (c <= LW + 1);
      n_chk++;
      if (lb_we !== exp_lb) begin
        n_fail++;
        $display("FAIL %s lb_we c=%0d got %b exp %b", name, c, lb_we, exp_lb);
      end
      if (exp_lb) begin
        n_chk++;
        if (lb_addr !== {exp_bank, 9'(c - 2)}) begin
          n_fail++;
          $display("FAIL %s lb_addr c=%0d got %h exp %h", name, c, lb_addr, {exp_bank, 9'(c - 2)});
        end
        n_chk++;
        if (lb_wdata !== pat(b + c - 2)) begin
          n_fail++;
          $display("FAIL %s lb_wdata c=%0d got %h exp %h", name, c, lb_wdata, pat(b + c - 2));
        end
      end
      exp_err = (err_at != 0) && (c == err_at + 1);
      n_chk++;
      if (req_err !== exp_err) begin
        n_fail++;
        $display("FAIL %s req_err c=%0d got %b exp %b", name, c, req_err, exp_err);
      end
      if (c == err_at) begin
        line_req = 1'b1;
        line_idx = 9'd7;
      end
      if (c < LW + 2) begin
        tick();
        line_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({mem_addr, mem_we, mem_wdata, wr_ack, lb_we, lb_addr, busy, req_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0",
               {mem_addr, mem_we, mem_wdata, wr_ack, lb_we, lb_addr, busy, req_err});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || lb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b lb_we=%b exp 0", busy, lb_we);
    end
  endtask

  task automatic test_single_fetch();
    run_fetch("fetch_idx3", 9'd3, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_fetch("b2b_first", 9'd0, 1'b1, 200);
    run_fetch("b2b_second", 9'd1, 1'b0, 0);
  endtask

  task automatic test_write_single();
    wr_req = 1'b1;
    wr_addr = 17'd100;
    wr_data = 8'h5A;
    tick();
    wr_req = 1'b0;
    n_chk++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_single_ack got ack=%b we=%b exp 1", wr_ack, mem_we);
    end
    n_chk++;
    if (mem_addr !== 17'd100 || mem_wdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_single_bus got %0d/%h exp 100/5a", mem_addr, mem_wdata);
    end
    tick();
    n_chk++;
    if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_single_pulse got ack=%b we=%b exp 0", wr_ack, mem_we);
    end
    n_chk++;
    if (wvld[100] !== 1'b1 || wmem[100] !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_single_ram got %b/%h exp 1/5a", wvld[100], wmem[100]);
    end
  endtask

  task automatic test_write_stream();
    int w;
    logic exp_ack;
    w = 0;
    wr_req = 1'b1;
    wr_addr = 17'd300;
    wr_data = 8'hA0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_ack = (c % 2 == 1) && (c <= 7);
      n_chk++;
      if (wr_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL wr_stream_ack c=%0d got %b exp %b", c, wr_ack, exp_ack);
      end
      if (wr_ack === 1'b1) begin
        w++;
        if (w < 4) begin
          wr_addr = 17'(300 + w);
          wr_data = 8'(8'hA0 + w);
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wmem[300 + i] !== 8'(8'hA0 + i)) begin
        n_fail++;
        $display("FAIL wr_stream_ram[%0d] got %h exp %h", 300 + i, wmem[300 + i], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_write_vs_fetch();
    wr_req = 1'b1;
    wr_addr = 17'd150;
    wr_data = 8'h77;
    run_fetch("wr_vs_fetch", 9'd2, 1'b1, 0);
    tick();
    wr_req = 1'b0;
    n_chk++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_after_fetch_ack got ack=%b we=%b exp 1", wr_ack, mem_we);
    end
    n_chk++;
    if (mem_addr !== 17'd150 || mem_wdata !== 8'h77) begin
      n_fail++;
      $display("FAIL wr_after_fetch_bus got %0d/%h exp 150/77", mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_bad_idx();
    line_req = 1'b1;
    line_idx = 9'd272;
    wr_req = 1'b1;
    wr_addr = 17'd200;
    wr_data = 8'h33;
    tick();
    line_req = 1'b0;
    wr_req = 1'b0;
    n_chk++;
    if (req_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_idx_err got err=%b busy=%b exp 1/0", req_err, busy);
    end
    n_chk++;
    if (wr_ack !== 1'b1 || mem_addr !== 17'd200 || mem_wdata !== 8'h33) begin
      n_fail++;
      $display("FAIL bad_idx_write got ack=%b %0d/%h exp 1 200/33", wr_ack, mem_addr, mem_wdata);
    end
    tick();
    n_chk++;
    if (req_err !== 1'b0 || busy !== 1'b0 || lb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_idx_after got err=%b busy=%b lb_we=%b exp 0", req_err, busy, lb_we);
    end
    run_fetch("bank_unchanged", 9'd4, 1'b0, 0);
  endtask

  task automatic test_reset_mid_fetch();
    line_req = 1'b1;
    line_idx = 9'd5;
    tick();
    line_req = 1'b0;
    repeat (99) tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_addr, mem_we, mem_wdata, wr_ack, lb_we, lb_addr, busy, req_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %h exp 0",
               {mem_addr, mem_we, mem_wdata, wr_ack, lb_we, lb_addr, busy, req_err});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if (lb_we !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_idle c=%0d got lb_we=%b busy=%b exp 0", c, lb_we, busy);
      end
    end
    run_fetch("after_reset", 9'd6, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_write_single();
    test_write_stream();
    test_write_vs_fetch();
    test_bad_idx();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
